// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU operation codes and multiplier FSM states.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_NOR   = 4'b1100,
    ALU_MUL   = 4'b1000
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier: N steps after start, low N product bits; start is ignored while busy.
// done marks the final step cycle, where product already carries the complete result.
module mul_iter #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic          busy_q, busy_d;
  logic [N-1:0]  acc_step;

  // Once all multiplier bits are consumed mplier_q is 0, so product equals acc_q.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product  = acc_step;
  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == LAST);

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    busy_d   = busy_q;
    if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (start) begin
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/execute_pipe.sv
// Execute stage: ALU, branch target and store data into a valid/ready output register, 1-cycle latency; holds while !out_ready.
// EXEC_MUL_EN adds an iterative MUL (code 4'b1000, N+1 cycle latency, stalls intake); otherwise that code yields 0.
module execute_pipe
  import exec_pkg::*;
#(
  parameter int N        = 64,
  parameter int BR_SHIFT = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] writeData_M,
  output logic         zero_M,
  output logic         busy
);

  logic [N-1:0] op_b, alu_res, pcb_calc;
  logic         out_free, accept, is_mul, load_alu, load_mul;
  logic [N-1:0] mul_res, mul_pcb, mul_wd;

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] res_q, res_d;
  logic [N-1:0] pcb_q, pcb_d;
  logic [N-1:0] wd_q, wd_d;
  logic         zero_q, zero_d;

  assign op_b     = AluSrc ? signImm_E : readData2_E;
  assign pcb_calc = PC_E + (signImm_E << BR_SHIFT);
  assign out_free = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign load_alu = accept && !is_mul;

  always_comb begin
    alu_res = '0;
    case (AluControl)
      ALU_AND:   alu_res = readData1_E & op_b;
      ALU_OR:    alu_res = readData1_E | op_b;
      ALU_ADD:   alu_res = readData1_E + op_b;
      ALU_SUB:   alu_res = readData1_E - op_b;
      ALU_PASSB: alu_res = op_b;
      ALU_NOR:   alu_res = ~(readData1_E | op_b);
      default:   alu_res = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  mul_state_t   state_q, state_d;
  logic         mul_busy, mul_done, product_rdy;
  logic [N-1:0] mul_product;
  logic [N-1:0] hold_pcb_q, hold_wd_q;

  assign is_mul = (AluControl == ALU_MUL);

  mul_iter #(.N(N)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept && is_mul),
    .a       (readData1_E),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // DONE only exists while an older result blocks the register; intake stays closed there too.
  assign product_rdy = ((state_q == MUL) && mul_done) || (state_q == DONE);
  assign load_mul    = product_rdy && out_free;
  assign busy        = mul_busy;
  assign in_ready    = !mul_busy && (state_q != DONE) && out_free;
  assign mul_res     = mul_product;
  assign mul_pcb     = hold_pcb_q;
  assign mul_wd      = hold_wd_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (mul_done) state_d = out_free ? IDLE : DONE;
      DONE: if (out_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_pcb_q <= '0;
      hold_wd_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept && is_mul) begin
        hold_pcb_q <= pcb_calc;
        hold_wd_q  <= readData2_E;
      end
    end
  end
`else
  assign is_mul   = 1'b0;
  assign load_mul = 1'b0;
  assign busy     = 1'b0;
  assign in_ready = out_free;
  assign mul_res  = '0;
  assign mul_pcb  = '0;
  assign mul_wd   = '0;
`endif

  // A pop clears valid unless a load in the same cycle refills the register.
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    pcb_d       = pcb_q;
    wd_d        = wd_q;
    zero_d      = zero_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (load_alu) begin
      out_valid_d = 1'b1;
      res_d       = alu_res;
      pcb_d       = pcb_calc;
      wd_d        = readData2_E;
      zero_d      = (alu_res == '0);
    end else if (load_mul) begin
      out_valid_d = 1'b1;
      res_d       = mul_res;
      pcb_d       = mul_pcb;
      wd_d        = mul_wd;
      zero_d      = (mul_res == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      pcb_q       <= '0;
      wd_q        <= '0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      pcb_q       <= pcb_d;
      wd_q        <= wd_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign aluResult_M = res_q;
  assign PCBranch_M  = pcb_q;
  assign writeData_M = wd_q;
  assign zero_M      = zero_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Scoreboard bench for execute_pipe: directed cases plus randomized traffic against a behavioural model.
module tb_execute_pipe;
  localparam int N   = 64;
  localparam int BRS = 2;

  typedef struct packed {
    logic [N-1:0] res;
    logic [N-1:0] pcb;
    logic [N-1:0] wd;
    logic         zero;
  } exp_t;

  logic         clk, reset_n, in_valid, in_ready, AluSrc, out_valid, out_ready, zero_M, busy;
  logic [3:0]   AluControl;
  logic [N-1:0] PC_E, signImm_E, readData1_E, readData2_E, PCBranch_M, aluResult_M, writeData_M;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   rand_rdy = 0;
  bit   busy_seen = 0;

  execute_pipe #(.N(N), .BR_SHIFT(BRS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .AluSrc      (AluSrc),
    .AluControl  (AluControl),
    .PC_E        (PC_E),
    .signImm_E   (signImm_E),
    .readData1_E (readData1_E),
    .readData2_E (readData2_E),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .PCBranch_M  (PCBranch_M),
    .aluResult_M (aluResult_M),
    .writeData_M (writeData_M),
    .zero_M      (zero_M),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected response straight from the operation table, with a full-width product for MUL.
  function automatic exp_t model(input logic [3:0] op, input logic src, input logic [N-1:0] a,
                                 input logic [N-1:0] r2, input logic [N-1:0] imm, input logic [N-1:0] pc);
    exp_t         e;
    logic [N-1:0] b;
    logic [2*N-1:0] prod;
    b    = src ? imm : r2;
    prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b0111: e.res = b;
      4'b1100: e.res = ~(a | b);
`ifdef EXEC_MUL_EN
      4'b1000: e.res = prod[N-1:0];
`endif
      default: e.res = '0;
    endcase
    e.pcb  = pc + (imm << BRS);
    e.wd   = r2;
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic src, input logic [N-1:0] a,
                      input logic [N-1:0] r2, input logic [N-1:0] imm, input logic [N-1:0] pc);
    int w = 0;
    AluControl  = op;
    AluSrc      = src;
    readData1_E = a;
    readData2_E = r2;
    signImm_E   = imm;
    PC_E        = pc;
    in_valid    = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      miscompares++;
      $display("FAIL send_timeout: in_ready stayed %b for %0d cycles, required 1", in_ready, w);
      step();
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(op, src, a, r2, imm, pc));
    step();
    in_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen = 1'b1;
      if (reset_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: result %h present, scoreboard empty", aluResult_M);
        end else begin
          e = sb.pop_front();
          chk("result", aluResult_M, e.res);
          chk("branch", PCBranch_M, e.pcb);
          chk("wdata", writeData_M, e.wd);
          chk("zero", N'(zero_M), N'(e.zero));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    logic [3:0] ops [10];
    int lat, bc, ir, ov;
    logic [3:0] op;
    logic [N-1:0] a, r2, imm, pc;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b0011, 4'b1111, 4'b1000};

    reset_n = 1'b0; in_valid = 1'b0; AluSrc = 1'b0; AluControl = 4'b0;
    PC_E = '0; signImm_E = '0; readData1_E = '0; readData2_E = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", N'(out_valid), '0);
    chk("rst_result", aluResult_M, '0);
    chk("rst_branch", PCBranch_M, '0);
    chk("rst_wdata", writeData_M, '0);
    chk("rst_zero", N'(zero_M), '0);
    chk("rst_busy", N'(busy), '0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", N'(in_ready), N'(1));

    step();
    send(4'b0010, 1'b1, N'(5), N'(99), -64'sd3, '0);
    @(negedge clk);
    chk("add_valid", N'(out_valid), N'(1));
    chk("add_result", aluResult_M, N'(2));
    chk("add_zero", N'(zero_M), '0);

    step();
    send(4'b0110, 1'b0, N'(7), N'(7), '0, '0);
    @(negedge clk);
    chk("sub_result", aluResult_M, '0);
    chk("sub_zero", N'(zero_M), N'(1));

    step();
    send(4'b0010, 1'b1, '0, '0, -64'sd4, N'(32'h1000));
    @(negedge clk);
    chk("branch_neg", PCBranch_M, N'(32'h0FF0));
    step();
    send(4'b0010, 1'b1, '0, '0, N'(1), -64'sd4);
    @(negedge clk);
    chk("branch_wrap", PCBranch_M, '0);

    step();
    out_ready = 1'b0;
    send(4'b0010, 1'b0, N'(10), N'(20), '0, '0);
    @(negedge clk);
    chk("bp_valid", N'(out_valid), N'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_result", aluResult_M, N'(30));
      chk("bp_hold_wdata", writeData_M, N'(20));
      chk("bp_in_ready", N'(in_ready), '0);
    end
    step();
    out_ready = 1'b1;
    send(4'b0110, 1'b0, N'(50), N'(8), '0, '0);
    @(negedge clk);
    chk("pop_accept_valid", N'(out_valid), N'(1));
    chk("pop_accept_result", aluResult_M, N'(42));

`ifdef EXEC_MUL_EN
    step();
    send(4'b1000, 1'b0, {N{1'b1}}, N'(3), '0, N'(32'h2000));
    lat = 0; bc = 0; ir = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (!out_valid && in_ready) ir++;
    end while (!out_valid && lat < 200);
    chk("mul_latency", N'(lat), N'(N + 1));
    chk("mul_busy_cycles", N'(bc), N'(N));
    chk("mul_in_ready_low", N'(ir), '0);
    chk("mul_result", aluResult_M, 64'hFFFF_FFFF_FFFF_FFFD);

    step();
    send(4'b1000, 1'b0, N'(12345), N'(678), '0, '0);
    repeat (29) step();
    reset_n = 1'b0;
    sb.delete();
    step();
    reset_n = 1'b1;
    ov = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    chk("mul_reset_no_output", N'(ov), '0);
    chk("mul_reset_busy", N'(busy), '0);
`else
    step();
    send(4'b1000, 1'b0, N'(6), N'(7), '0, '0);
    @(negedge clk);
    chk("nomul_valid", N'(out_valid), N'(1));
    chk("nomul_result", aluResult_M, '0);
    chk("nomul_zero", N'(zero_M), N'(1));
`endif

    step();
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op  = ops[$urandom_range(0, 9)];
      a   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : {$urandom, $urandom};
      r2  = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : {$urandom, $urandom};
      imm = ($urandom_range(0, 1) == 0) ? N'(signed'($urandom_range(0, 15)) - 8) : {$urandom, $urandom};
      pc  = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) step();
      send(op, 1'($urandom_range(0, 1)), a, r2, imm, pc);
    end
    rand_rdy = 1'b0;
    step();
    out_ready = 1'b1;
    lat = 0;
    while (sb.size() != 0 && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    chk("drain_empty", N'(sb.size()), '0);

    step();
    out_ready = 1'b0;
    send(4'b0001, 1'b0, N'(1), N'(2), N'(3), N'(4));
    reset_n = 1'b0;
    sb.delete();
    #2;
    chk("midrst_valid", N'(out_valid), '0);
    chk("midrst_result", aluResult_M, '0);
    chk("midrst_branch", PCBranch_M, '0);
    chk("midrst_wdata", writeData_M, '0);
    chk("midrst_zero", N'(zero_M), '0);
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", N'(in_ready), N'(1));

`ifndef EXEC_MUL_EN
    chk("busy_never_high", N'(busy_seen), '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
